pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: sequential advance, trap/jump redirects with a
// wait state when the fetch bus is busy, and misaligned-jump reporting.
module pc_gen #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter bit          RVC_SUPPORT  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_sync,
   input  logic        stall_n,
   input  logic        fetch_ready,
   input  logic        is_compressed,
   input  logic        jump,
   input  logic [31:0] jump_addr,
   input  logic        trap,
   input  logic [31:0] trap_addr,
   output logic [31:0] pc,
   output logic        fetch_valid,
   output logic        redirect_busy,
   output logic        misaligned_exc,
   output logic [31:0] misaligned_addr
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      REDIRECT_WAIT
   } state_t;

   state_t      state;
   logic [31:0] target_q;

   logic        fire;
   logic        jump_misaligned;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] jump_target;
   logic [31:0] pc_step;

   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      fire            = fetch_valid & fetch_ready;
      jump_target     = {jump_addr[31:1], 1'b0};
      jump_misaligned = jump & ~trap & ~RVC_SUPPORT & jump_addr[1];
      redirect        = trap | (jump & ~jump_misaligned);
      redirect_target = jump_target;
      if (trap) begin
         redirect_target = {trap_addr[31:2], 2'b00};
      end
      pc_step = (RVC_SUPPORT && is_compressed) ? 32'd2 : 32'd4;
   end

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state           <= BOOT;
         pc              <= RESET_VECTOR;
         target_q        <= '0;
         fetch_valid     <= 1'b0;
         redirect_busy   <= 1'b0;
         misaligned_exc  <= 1'b0;
         misaligned_addr <= '0;
      end else begin
         // Misaligned jumps are reported from any active state; BOOT ignores jumps.
         misaligned_exc <= (state != BOOT) && jump_misaligned;
         if ((state != BOOT) && jump_misaligned) begin
            misaligned_addr <= jump_target;
         end

         case (state)
            BOOT: begin
               state       <= RUN;
               fetch_valid <= 1'b1;
            end

            RUN: begin
               if (redirect) begin
                  if (fire) begin
                     pc <= redirect_target;
                  end else begin
                     target_q      <= redirect_target;
                     state         <= REDIRECT_WAIT;
                     redirect_busy <= 1'b1;
                  end
               end else if (fire && stall_n) begin
                  pc <= pc + pc_step;
               end
            end

            REDIRECT_WAIT: begin
               // A fresh redirect supersedes the latched one, even on acceptance.
               if (fire) begin
                  pc            <= redirect ? redirect_target : target_q;
                  state         <= RUN;
                  redirect_busy <= 1'b0;
               end else if (redirect) begin
                  target_q <= redirect_target;
               end
            end

            default: begin
               state         <= BOOT;
               fetch_valid   <= 1'b0;
               redirect_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (RVC off with RESET_VECTOR=0x100, RVC on with
// RESET_VECTOR=0) share stimulus and are checked every cycle against a model.
module tb_pc_gen;

   logic        clk;
   logic        rst_sync;
   logic        stall_n;
   logic        fetch_ready;
   logic        is_compressed;
   logic        jump;
   logic [31:0] jump_addr;
   logic        trap;
   logic [31:0] trap_addr;

   logic [31:0] pc0, pc1;
   logic        fv0, fv1;
   logic        busy0, busy1;
   logic        exc0, exc1;
   logic [31:0] maddr0, maddr1;

   int n_compared   = 0;
   int n_mismatched = 0;

   pc_gen #(.RESET_VECTOR(32'h0000_0100), .RVC_SUPPORT(1'b0)) dut0 (
      .clk(clk), .rst_sync(rst_sync), .stall_n(stall_n), .fetch_ready(fetch_ready),
      .is_compressed(is_compressed), .jump(jump), .jump_addr(jump_addr),
      .trap(trap), .trap_addr(trap_addr), .pc(pc0), .fetch_valid(fv0),
      .redirect_busy(busy0), .misaligned_exc(exc0), .misaligned_addr(maddr0)
   );

   pc_gen #(.RESET_VECTOR(32'h0000_0000), .RVC_SUPPORT(1'b1)) dut1 (
      .clk(clk), .rst_sync(rst_sync), .stall_n(stall_n), .fetch_ready(fetch_ready),
      .is_compressed(is_compressed), .jump(jump), .jump_addr(jump_addr),
      .trap(trap), .trap_addr(trap_addr), .pc(pc1), .fetch_valid(fv1),
      .redirect_busy(busy1), .misaligned_exc(exc1), .misaligned_addr(maddr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural view: current pc, whether the boot cycle is pending, and an
   // optional pending redirect target.
   typedef struct packed {
      logic [31:0] pc;
      logic        boot;
      logic        pending;
      logic [31:0] ptarget;
      logic        exc;
      logic [31:0] maddr;
   } model_t;

   model_t m0, m1;

   function automatic model_t model_next(model_t m, bit rvc, logic [31:0] rv);
      model_t      n = m;
      logic        bad;
      logic        have;
      logic [31:0] tgt;
      if (rst_sync) begin
         n.pc = rv; n.boot = 1'b1; n.pending = 1'b0;
         n.ptarget = '0; n.exc = 1'b0; n.maddr = '0;
         return n;
      end
      if (m.boot) begin
         n.boot = 1'b0; n.exc = 1'b0;
         return n;
      end
      bad   = jump && !trap && !rvc && jump_addr[1];
      n.exc = bad;
      if (bad) n.maddr = jump_addr & 32'hFFFF_FFFE;
      have = 1'b0;
      tgt  = '0;
      if (trap) begin
         have = 1'b1; tgt = trap_addr & 32'hFFFF_FFFC;
      end else if (jump && !bad) begin
         have = 1'b1; tgt = jump_addr & 32'hFFFF_FFFE;
      end
      if (have) begin
         if (fetch_ready) begin
            n.pc = tgt; n.pending = 1'b0;
         end else begin
            n.pending = 1'b1; n.ptarget = tgt;
         end
      end else if (m.pending) begin
         if (fetch_ready) begin
            n.pc = m.ptarget; n.pending = 1'b0;
         end
      end else if (fetch_ready && stall_n) begin
         n.pc = m.pc + ((rvc && is_compressed) ? 32'd2 : 32'd4);
      end
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_dut(input string tag, input model_t m, input logic [31:0] p,
                              input logic fv, input logic bz, input logic ex,
                              input logic [31:0] ma);
      check({tag, ".pc"}, p, m.pc);
      check({tag, ".fetch_valid"}, 32'(fv), 32'(!m.boot));
      check({tag, ".redirect_busy"}, 32'(bz), 32'(m.pending));
      check({tag, ".misaligned_exc"}, 32'(ex), 32'(m.exc));
      check({tag, ".misaligned_addr"}, ma, m.maddr);
   endtask

   // Called at a negedge with inputs already applied: predict, cross one
   // rising edge, then compare at the following negedge.
   task automatic tick();
      m0 = model_next(m0, 1'b0, 32'h0000_0100);
      m1 = model_next(m1, 1'b1, 32'h0000_0000);
      @(negedge clk);
      compare_dut("dut0", m0, pc0, fv0, busy0, exc0, maddr0);
      compare_dut("dut1", m1, pc1, fv1, busy1, exc1, maddr1);
   endtask

   task automatic cyc(input bit r, input bit s, input bit rd, input bit c,
                      input bit j, input logic [31:0] ja, input bit t, input logic [31:0] ta);
      rst_sync = r; stall_n = s; fetch_ready = rd; is_compressed = c;
      jump = j; jump_addr = ja; trap = t; trap_addr = ta;
      tick();
   endtask

   initial begin
      rst_sync = 1'b1; stall_n = 1'b1; fetch_ready = 1'b0; is_compressed = 1'b0;
      jump = 1'b0; jump_addr = '0; trap = 1'b0; trap_addr = '0;
      m0 = '0; m1 = '0;
      @(negedge clk);

      // Reset, boot cycle, sequential run (RVC off: +4; RVC on: 1,0,1 pattern)
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      check("reset.pc0", pc0, 32'h100);
      check("reset.fv0", 32'(fv0), 32'h0);
      check("reset.pc1", pc1, 32'h0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("boot.pc0", pc0, 32'h100);
      check("boot.fv0", 32'(fv0), 32'h1);
      cyc(0, 1, 1, 1, 0, 0, 0, 0);
      check("seq1.pc0", pc0, 32'h104);
      check("rvc1.pc1", pc1, 32'h2);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("seq2.pc0", pc0, 32'h108);
      check("rvc2.pc1", pc1, 32'h6);
      cyc(0, 1, 1, 1, 0, 0, 0, 0);
      check("seq3.pc0", pc0, 32'h10C);
      check("rvc3.pc1", pc1, 32'h8);

      // Redirect while fetch bus busy
      cyc(0, 1, 1, 0, 1, 32'h20, 0, 0);
      check("jmp20.pc0", pc0, 32'h20);
      cyc(0, 1, 0, 0, 1, 32'h40, 0, 0);
      check("wait.pc0", pc0, 32'h20);
      check("wait.busy0", 32'(busy0), 32'h1);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("accept.pc0", pc0, 32'h40);
      check("accept.busy0", 32'(busy0), 32'h0);

      // Trap beats jump; misaligned jump
      cyc(0, 1, 1, 0, 1, 32'h40, 1, 32'h83);
      check("trap.pc0", pc0, 32'h80);
      check("trap.pc1", pc1, 32'h80);
      cyc(0, 1, 1, 0, 1, 32'h42, 0, 0);
      check("mis.exc0", 32'(exc0), 32'h1);
      check("mis.addr0", maddr0, 32'h42);
      check("mis.pc0", pc0, 32'h84);
      check("rvcjmp.pc1", pc1, 32'h42);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("mis_end.exc0", 32'(exc0), 32'h0);
      check("mis_hold.addr0", maddr0, 32'h42);

      // Wraparound and stall
      cyc(0, 1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("wrap.pc0", pc0, 32'h0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      check("stall.pc0", pc0, 32'h0);

      // Reset during REDIRECT_WAIT discards the pending target
      cyc(0, 1, 0, 0, 1, 32'h200, 0, 0);
      check("rw.busy0", 32'(busy0), 32'h1);
      cyc(1, 1, 1, 0, 0, 0, 0, 0);
      check("rwrst.pc0", pc0, 32'h100);
      check("rwrst.busy0", 32'(busy0), 32'h0);
      check("rwrst.fv0", 32'(fv0), 32'h0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("reboot.pc0", pc0, 32'h100);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("reboot_seq.pc0", pc0, 32'h104);

      // Overwrite of the latched target
      cyc(0, 1, 0, 0, 1, 32'h300, 0, 0);
      cyc(0, 1, 0, 0, 1, 32'h400, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 1, 32'h503);
      check("ovr_trap.pc0", pc0, 32'h500);
      cyc(0, 1, 0, 0, 1, 32'h600, 0, 0);
      cyc(0, 1, 0, 0, 1, 32'h700, 0, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0);
      check("ovr_latch.pc0", pc0, 32'h700);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 127) == 0),
             ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 9) < 7),
             1'($urandom),
             ($urandom_range(0, 5) == 0),
             (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + ($urandom & 32'hF) : $urandom),
             ($urandom_range(0, 11) == 0),
             $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
